mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between two requesters: the instruction fetch path (PC/ROM side) and the data memory stage (load/store).
- Runs a small FSM that issues one memory command at a time and waits a fixed read latency.
- Returns data and a one-cycle acknowledge to the requester that was granted.
- Drives a stall to the PC and pipeline registers while any request is still waiting for its acknowledge.

---
 rtl/mem_port_arbiter_pkg.sv | 50 +++++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_arb_starve_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  // Width of the latency and starvation counters.
  localparam int unsigned CNT_W = 4;

  // Owner encoding of a granted access.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyIf = 2'd1,
    StBusyDm = 2'd2,
    StResp   = 2'd3
  } arb_state_e;

  // Result of one arbitration decision.
  typedef struct packed {
    logic grant;
    logic owner;
    logic inc;    // data port won while fetch was waiting
    logic clr;    // fetch won, starvation history is cleared
  } arb_pick_t;

  // Data port wins conflicts until fetch has been passed over at_limit times.
  function automatic arb_pick_t arb_pick(input logic if_m, input logic dm_m, input logic at_limit);
    arb_pick_t p;
    p = '0;
    if (if_m && dm_m) begin
      p.grant = 1'b1;
      if (at_limit) begin
        p.owner = OWNER_IF;
        p.clr   = 1'b1;
      end else begin
        p.owner = OWNER_DM;
        p.inc   = 1'b1;
      end
    end else if (dm_m) begin
      p.grant = 1'b1;
      p.owner = OWNER_DM;
    end else if (if_m) begin
      p.grant = 1'b1;
      p.owner = OWNER_IF;
      p.clr   = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the unified memory port arbiter.
// slave: arbiter side; master: the surrounding pipeline / memory / bench.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  stall_o
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data-port wins over a waiting fetch; at_limit_o forces fetch to win.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CNT_W'(STARVE_LIMIT));

  // Clear wins over increment; never count past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: fetch and data ports share one single-port memory.
// One access in flight at a time; fixed read latency; one-cycle ack to the owner.
// Optional MEM_ARB_PERF_CNT_EN adds conflict_cnt_o (grants made while both ports wait).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus_io
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt_o
`endif
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("MEM_LATENCY must be in 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT must be in 1..15");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              mem_en_q, mem_en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic       if_m, dm_m;
  logic       starve_at_limit;
  logic       starve_inc, starve_clr;
  logic       arb_window;
  arb_pick_t  pick;

  // A port being acknowledged this cycle still shows its old request; mask it so
  // the completed access is not granted a second time.
  assign if_m = bus_io.if_req_i & ~if_ack_q;
  assign dm_m = bus_io.dm_req_i & ~dm_ack_q;

  assign arb_window = (state_q == StIdle) || (state_q == StResp);
  assign pick       = arb_pick(if_m, dm_m, starve_at_limit);

  assign bus_io.stall_o     = if_m | dm_m;
  assign bus_io.mem_en_o    = mem_en_q;
  assign bus_io.mem_we_o    = we_q;
  assign bus_io.mem_addr_o  = addr_q;
  assign bus_io.mem_wdata_o = wdata_q;
  assign bus_io.if_ack_o    = if_ack_q;
  assign bus_io.dm_ack_o    = dm_ack_q;
  assign bus_io.if_rdata_o  = if_rdata_q;
  assign bus_io.dm_rdata_o  = dm_rdata_q;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i     (clk),
    .reset_i   (reset),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .at_limit_o(starve_at_limit)
  );

  // Next-state: arbitrate in IDLE/RESP, count down the read latency in BUSY.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    mem_en_d   = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (pick.grant) begin
          mem_en_d   = 1'b1;
          starve_inc = pick.inc;
          starve_clr = pick.clr;
          if (pick.owner == OWNER_IF) begin
            state_d = StBusyIf;
            addr_d  = bus_io.if_addr_i;
            we_d    = 1'b0;
          end else begin
            state_d = StBusyDm;
            addr_d  = bus_io.dm_addr_i;
            we_d    = bus_io.dm_we_i;
            wdata_d = bus_io.dm_wdata_i;
          end
        end
      end

      StBusyIf, StBusyDm: begin
        if (mem_en_q) begin
          // Command cycle: start the latency countdown.
          lat_d = CNT_W'(MEM_LATENCY);
        end else begin
          lat_d = lat_q - CNT_W'(1);
          if (lat_q == CNT_W'(1)) begin
            // Read data is valid this cycle.
            state_d = StResp;
            if (state_q == StBusyIf) begin
              if_ack_d   = 1'b1;
              if_rdata_d = bus_io.mem_rdata_i;
            end else begin
              dm_ack_d = 1'b1;
              if (!we_q) begin
                dm_rdata_d = bus_io.mem_rdata_i;
              end
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      mem_en_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      mem_en_q   <= mem_en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;
  logic        conflict_evt;

  assign conflict_evt   = arb_window & pick.grant & if_m & dm_m;
  assign conflict_cnt_o = conflict_cnt_q;

  // Counts grants made while both masked requests were pending; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else if (conflict_evt) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end
`else
  logic unused_arb_window;
  assign unused_arb_window = arb_window;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle compare against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          LAT  = 1;
  localparam int          SLIM = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(SLIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o(conflict_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory seen by the DUT, and the model's own shadow copy.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] shadow  [logic [31:0]];
  int          pend_cyc = -1;
  logic [31:0] pend_dat = '0;

  // Model state: one access at a time, timed by its age in cycles since grant.
  bit          m_busy = 0;
  bit          m_own  = 0;
  int          m_age  = 0;
  logic [31:0] m_addr = '0;
  bit          m_we   = 0;
  logic [31:0] m_wdat = '0;
  logic [31:0] m_word = '0;
  int          m_starve = 0;
  logic [31:0] e_if_rd = '0;
  logic [31:0] e_dm_rd = '0;
  logic [31:0] e_conf  = '0;

  // Per-cycle monitor: compare, advance the model, then act as the memory.
  initial begin
    bit e_en, e_ia, e_da, e_st, free, ifm, dmm, g_if, g_dm;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      e_en = m_busy && (m_age == 1);
      e_ia = m_busy && (m_age == LAT + 2) && !m_own;
      e_da = m_busy && (m_age == LAT + 2) && m_own;
      e_st = (bus.if_req_i && !e_ia) || (bus.dm_req_i && !e_da);
      if (chk_en) begin
        chk("mem_en", bus.mem_en_o, e_en);
        if (e_en) begin
          chk("mem_addr", bus.mem_addr_o, m_addr);
          chk("mem_we", bus.mem_we_o, m_we);
          if (m_we) chk("mem_wdata", bus.mem_wdata_o, m_wdat);
        end
        chk("if_ack", bus.if_ack_o, e_ia);
        chk("dm_ack", bus.dm_ack_o, e_da);
        chk("if_rdata", bus.if_rdata_o, e_if_rd);
        chk("dm_rdata", bus.dm_rdata_o, e_dm_rd);
        chk("stall", bus.stall_o, e_st);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("conflict_cnt", conflict_cnt, e_conf);
`endif
      end

      if (reset) begin
        m_busy = 0; m_starve = 0; e_if_rd = '0; e_dm_rd = '0; e_conf = '0;
      end else begin
        free = !m_busy || (m_age == LAT + 2);
        if (m_busy && m_age == LAT + 1) begin
          if (!m_own) e_if_rd = m_word;
          else if (!m_we) e_dm_rd = m_word;
        end
        if (free) begin
          ifm = bus.if_req_i && !e_ia;
          dmm = bus.dm_req_i && !e_da;
          g_if = 0; g_dm = 0;
          if (ifm && dmm) begin
            e_conf = e_conf + 1;
            if (m_starve < SLIM) begin g_dm = 1; m_starve++; end
            else g_if = 1;
          end else if (dmm) g_dm = 1;
          else if (ifm) g_if = 1;
          m_busy = g_if || g_dm;
          m_age  = 1;
          if (g_if) begin
            m_starve = 0; m_own = 0; m_addr = bus.if_addr_i; m_we = 0;
          end else if (g_dm) begin
            m_own = 1; m_addr = bus.dm_addr_i; m_we = bus.dm_we_i; m_wdat = bus.dm_wdata_i;
          end
          if (m_busy) begin
            m_word = shadow.exists(m_addr) ? shadow[m_addr] : def_word(m_addr);
            if (m_we) shadow[m_addr] = m_wdat;
          end
        end else begin
          m_age++;
        end
      end

      if (bus.mem_en_o === 1'b1) begin
        a = bus.mem_addr_o;
        pend_cyc = cyc + LAT;
        pend_dat = mem_arr.exists(a) ? mem_arr[a] : def_word(a);
        if (bus.mem_we_o === 1'b1) mem_arr[a] = bus.mem_wdata_o;
      end
      bus.mem_rdata_i = (cyc == pend_cyc) ? pend_dat : (32'hBAD0_0000 + 32'(cyc));
    end
  end

  task automatic drive_pt();
    @(posedge clk);
    #2;
  endtask

  task automatic obs_pt();
    @(negedge clk);
    #1;
  endtask

  // Waits for one ack on the given port, dropping its request in the ack cycle.
  task automatic run_single(input bit dm, input int budget, output int en_c, output int ack_c,
                            output int en_n, output int stall_n, output logic we_en,
                            output logic [31:0] rdat);
    en_c = -1; ack_c = -1; en_n = 0; stall_n = 0; we_en = 0; rdat = '0;
    for (int k = 0; k < budget; k++) begin
      obs_pt();
      if (bus.stall_o) stall_n++;
      if (bus.mem_en_o) begin en_n++; en_c = cyc; we_en = bus.mem_we_o; end
      if (dm ? bus.dm_ack_o : bus.if_ack_o) begin
        ack_c = cyc;
        rdat  = dm ? bus.dm_rdata_o : bus.if_rdata_o;
        if (dm) bus.dm_req_i = 0; else bus.if_req_i = 0;
        break;
      end
    end
    chk("ack_seen", ack_c >= 0, 1);
  endtask

  int          ack_own [8];
  int          ack_cyc [8];
  logic [31:0] ack_dat [8];
  int          ack_n;

  // Collects n acks; a port's request drops on its ack once ack index >= keep_until.
  task automatic collect_acks(input int n, input int keep_until, input int budget);
    ack_n = 0;
    for (int k = 0; k < budget && ack_n < n; k++) begin
      obs_pt();
      if (bus.dm_ack_o) begin
        ack_own[ack_n] = 1; ack_cyc[ack_n] = cyc; ack_dat[ack_n] = bus.dm_rdata_o; ack_n++;
        if (ack_n >= keep_until) bus.dm_req_i = 0;
      end else if (bus.if_ack_o) begin
        ack_own[ack_n] = 0; ack_cyc[ack_n] = cyc; ack_dat[ack_n] = bus.if_rdata_o; ack_n++;
        if (ack_n >= keep_until) bus.if_req_i = 0;
      end
    end
    chk("ack_count", ack_n, n);
  endtask

  task automatic do_reset();
    drive_pt();
    reset = 1;
    bus.if_req_i = 0;
    bus.dm_req_i = 0;
    drive_pt();
    drive_pt();
    reset = 0;
  endtask

  initial begin
    int r, en_c, ack_c, en_n, st_n, dmacks;
    logic we_en;
    logic [31:0] rd;

    mem_arr[32'h10] = 32'h2008_0005;
    shadow[32'h10]  = 32'h2008_0005;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_rdata_i = '0;

    repeat (3) @(posedge clk);
    #2 reset = 0;
    chk_en = 1;

    // Reset state.
    obs_pt();
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_if_ack", bus.if_ack_o, 0);
    chk("rst_dm_ack", bus.dm_ack_o, 0);
    chk("rst_if_rdata", bus.if_rdata_o, 0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 0);
    chk("rst_stall", bus.stall_o, 0);

    // Fetch only.
    drive_pt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h0000_0010; r = cyc + 1;
    run_single(0, 20, en_c, ack_c, en_n, st_n, we_en, rd);
    chk("s1_en_lat", en_c - r, 1);
    chk("s1_ack_lat", ack_c - r, 3);
    chk("s1_en_count", en_n, 1);
    chk("s1_rdata", rd, 32'h2008_0005);
    chk("s1_stall_cycles", st_n, 3);

    // Data load, then store, then load back.
    drive_pt();
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h1001_0004; r = cyc + 1;
    run_single(1, 20, en_c, ack_c, en_n, st_n, we_en, rd);
    chk("s2_load_rdata", rd, 32'h0004_FFFB);
    drive_pt();
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_wdata_i = 32'hDEAD_BEEF; r = cyc + 1;
    run_single(1, 20, en_c, ack_c, en_n, st_n, we_en, rd);
    chk("s2_store_en_count", en_n, 1);
    chk("s2_store_we", we_en, 1);
    chk("s2_store_ack_lat", ack_c - r, 3);
    chk("s2_store_rdata_held", rd, 32'h0004_FFFB);
    chk("s2_if_rdata_held", bus.if_rdata_o, 32'h2008_0005);
    drive_pt();
    bus.dm_req_i = 1; bus.dm_we_i = 0;
    run_single(1, 20, en_c, ack_c, en_n, st_n, we_en, rd);
    chk("s2_readback", rd, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, fetch follows with no idle cycle.
    drive_pt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h20;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h100; r = cyc + 1;
    collect_acks(2, 1, 30);
    chk("s3_first_owner", ack_own[0], 1);
    chk("s3_dm_ack_lat", ack_cyc[0] - r, 3);
    chk("s3_if_after_dm", ack_cyc[1] - ack_cyc[0], 3);
    chk("s3_dm_rdata", ack_dat[0], 32'h0100_FEFF);
    chk("s3_if_rdata", ack_dat[1], 32'h0020_FFDF);

    // Both requesters re-request immediately after every ack.
    drive_pt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h30;
    bus.dm_req_i = 1; bus.dm_addr_i = 32'h300; r = cyc + 1;
    collect_acks(6, 5, 60);
    for (int i = 0; i < 6; i++) begin
      chk("s4_owner", ack_own[i], (i % 2 == 0) ? 1 : 0);
      chk("s4_ack_cycle", ack_cyc[i] - r, 3 * (i + 1));
    end
    chk("s4_if_rdata", ack_dat[1], 32'h0030_FFCF);

    // Starvation: fetch passed over SLIM times, then forced to win.
    do_reset();
    for (int ep = 0; ep < SLIM; ep++) begin
      drive_pt();
      bus.if_req_i = 1; bus.if_addr_i = 32'h40;
      bus.dm_req_i = 1; bus.dm_addr_i = 32'h200;
      drive_pt();
      bus.if_req_i = 0;
      collect_acks(1, 1, 20);
      chk("s5_pre_owner", ack_own[0], 1);
      drive_pt();
    end
    drive_pt();
    bus.if_req_i = 1; bus.dm_req_i = 1;
    collect_acks(2, 1, 30);
    chk("s5_forced_owner", ack_own[0], 0);
    chk("s5_then_dm", ack_own[1], 1);
    chk("s5_gap", ack_cyc[1] - ack_cyc[0], 3);

    // Reset during a data access abandons it.
    drive_pt();
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h500;
    drive_pt();
    reset = 1; bus.dm_req_i = 0;
    drive_pt();
    reset = 0;
    obs_pt();
    chk("s6_mem_en", bus.mem_en_o, 0);
    chk("s6_mem_we", bus.mem_we_o, 0);
    chk("s6_mem_addr", bus.mem_addr_o, 0);
    chk("s6_mem_wdata", bus.mem_wdata_o, 0);
    chk("s6_dm_ack", bus.dm_ack_o, 0);
    chk("s6_if_rdata", bus.if_rdata_o, 0);
    chk("s6_dm_rdata", bus.dm_rdata_o, 0);
    chk("s6_stall", bus.stall_o, 0);
    dmacks = 0;
    for (int k = 0; k < 6; k++) begin
      obs_pt();
      if (bus.dm_ack_o) dmacks++;
    end
    chk("s6_no_dm_ack", dmacks, 0);
    drive_pt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h80; r = cyc + 1;
    run_single(0, 20, en_c, ack_c, en_n, st_n, we_en, rd);
    chk("s6_if_ack_lat", ack_c - r, 3);
    chk("s6_if_rdata_after", rd, 32'h0080_FF7F);

    repeat (3) drive_pt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
